// File: rtl/div_ctrl_pkg.sv
// Shared defaults and types for the multi-channel clock divider.
// Optional feature macro: DIV_CTRL_SYNC_EN (adds the sync_in restart input).
package div_ctrl_pkg;
  localparam int NCH_DEF   = 3;
  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    CH_OFF  = 2'd0,
    CH_RUN  = 2'd1,
    CH_PEND = 2'd2
  } ch_state_e;

  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/div_ctrl_chan.sv
// One divider channel: half-period counter, shadow register for glitch-free updates, FSM.
// Optional feature macro: DIV_CTRL_SYNC_EN (sync_in restarts the channel in phase).
module div_ctrl_chan
  import div_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             CLK_in,
  input  logic             RST,
`ifdef DIV_CTRL_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);
  ch_state_e        state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] shadow;
  logic             term;

  assign term = (cnt == div - DIV_W'(1));

`ifdef DIV_CTRL_SYNC_EN
  logic             sync_hit;
  logic [DIV_W-1:0] sync_div;
  // A write in the sync cycle wins over any staged value; PEND never accepts writes.
  assign sync_hit = sync_in && (state != CH_OFF);
  assign sync_div = wr ? wr_div : ((state == CH_PEND) ? shadow : div);
`endif

  always_ff @(posedge CLK_in) begin
    if (RST) begin
      state   <= CH_OFF;
      cnt     <= '0;
      div     <= '0;
      shadow  <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
`ifdef DIV_CTRL_SYNC_EN
    end else if (sync_hit) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      busy    <= 1'b0;
      shadow  <= '0;
      tick    <= clk_out && (sync_div != '0);
      div     <= sync_div;
      state   <= (sync_div == '0) ? CH_OFF : CH_RUN;
`endif
    end else begin
      tick <= 1'b0;
      unique case (state)
        CH_OFF: begin
          if (wr && (wr_div != '0)) begin
            state   <= CH_RUN;
            div     <= wr_div;
            cnt     <= '0;
            clk_out <= 1'b0;
          end
        end
        CH_RUN: begin
          if (term) begin
            cnt     <= '0;
            clk_out <= !clk_out;
            tick    <= 1'b1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
          // A write on a terminal-count cycle still waits for the next falling edge.
          if (wr) begin
            shadow <= wr_div;
            busy   <= 1'b1;
            state  <= CH_PEND;
          end
        end
        CH_PEND: begin
          if (term && clk_out) begin
            busy    <= 1'b0;
            shadow  <= '0;
            cnt     <= '0;
            clk_out <= 1'b0;
            if (shadow == '0) begin
              state <= CH_OFF;
              div   <= '0;
            end else begin
              state <= CH_RUN;
              div   <= shadow;
              tick  <= 1'b1;
            end
          end else if (term) begin
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= CH_OFF;
      endcase
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-channel programmable clock divider: write handshake decode plus NCH channel instances.
// Optional feature macro: DIV_CTRL_SYNC_EN (adds sync_in to restart all channels in phase).
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             CLK_in,
  input  logic             RST,
`ifdef DIV_CTRL_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);
  logic [3:0] busy_ext;

  // Unimplemented channel indices read as ready so their writes are silently dropped.
  assign busy_ext  = 4'(busy);
  assign cfg_ready = !busy_ext[cfg_ch];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && cfg_ready && (cfg_ch == ch_idx_t'(i));

    div_ctrl_chan #(.DIV_W(DIV_W)) u_chan (
      .CLK_in  (CLK_in),
      .RST     (RST),
`ifdef DIV_CTRL_SYNC_EN
      .sync_in (sync_in),
`endif
      .wr      (wr),
      .wr_div  (cfg_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .busy    (busy[i])
    );
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl against a timeline model (phase from cycle arithmetic).
// Define DIV_CTRL_SYNC_EN to also exercise sync_in.
module tb_div_ctrl;
  localparam int NCH   = 3;
  localparam int DIV_W = 8;

  logic             CLK_in = 1'b0;
  logic             RST = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [NCH-1:0]   clk_out, tick, busy;
`ifdef DIV_CTRL_SYNC_EN
  logic             sync_in = 1'b0;
`endif

  int total = 0, bad = 0, cyc = 0;

  // Model: a running channel's waveform is a pure function of (cycle - t0) and D.
  bit m_on[4], m_pend[4], m_tk0[4];
  int m_d[4], m_t0[4], m_pd[4];

  always #5 CLK_in = ~CLK_in;

  div_ctrl #(.NCH(NCH), .DIV_W(DIV_W)) dut (
    .CLK_in    (CLK_in),
    .RST       (RST),
`ifdef DIV_CTRL_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic bit exp_clk(input int i, input int n);
    if (!m_on[i]) return 1'b0;
    return (((n - m_t0[i]) / m_d[i]) % 2) == 1;
  endfunction

  function automatic bit exp_tick(input int i, input int n);
    int k;
    if (!m_on[i]) return 1'b0;
    k = n - m_t0[i];
    return ((k % m_d[i]) == 0) && ((k > 0) || m_tk0[i]);
  endfunction

  task automatic step(input bit rst, input bit v, input int ch, input int d, input bit sy);
    bit acc, w;
    bit pclk[4];
    int nd;
    RST = rst; cfg_valid = v; cfg_ch = 2'(ch); cfg_div = DIV_W'(d);
`ifdef DIV_CTRL_SYNC_EN
    sync_in = sy;
`endif
    #1;
    chk("cfg_ready", 32'(cfg_ready), 32'((ch >= NCH) || !m_pend[ch]));
    acc = v && !rst && (ch < NCH) && !m_pend[ch];
    @(posedge CLK_in);
    for (int i = 0; i < NCH; i++) pclk[i] = exp_clk(i, cyc);
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      w = acc && (ch == i);
      if (rst) begin
        m_on[i] = 0; m_pend[i] = 0;
      end else if (sy && m_on[i]) begin
        nd = w ? d : (m_pend[i] ? m_pd[i] : m_d[i]);
        m_pend[i] = 0;
        if (nd == 0) m_on[i] = 0;
        else begin m_d[i] = nd; m_t0[i] = cyc; m_tk0[i] = pclk[i]; end
      end else begin
        // Staged value lands only on a falling edge, i.e. a whole number of periods in.
        if (m_pend[i] && ((cyc - m_t0[i]) % (2 * m_d[i])) == 0) begin
          m_pend[i] = 0;
          if (m_pd[i] == 0) m_on[i] = 0;
          else begin m_d[i] = m_pd[i]; m_t0[i] = cyc; m_tk0[i] = 1; end
        end
        if (w) begin
          if (m_on[i]) begin m_pend[i] = 1; m_pd[i] = d; end
          else if (d != 0) begin m_on[i] = 1; m_d[i] = d; m_t0[i] = cyc; m_tk0[i] = 0; end
        end
      end
    end
    #1;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("clk_out%0d", i), 32'(clk_out[i]), 32'(exp_clk(i, cyc)));
      chk($sformatf("tick%0d", i),    32'(tick[i]),    32'(exp_tick(i, cyc)));
      chk($sformatf("busy%0d", i),    32'(busy[i]),    32'(m_pend[i]));
    end
    @(negedge CLK_in);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit r, v, sy;
    int ch, d;
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 5, 0);
    // D=1 on ch0: toggles every cycle with tick always high
    step(0, 1, 0, 1, 0);
    idle(8);
    // D=5 on ch1, then restage D=2 in the high phase; second write is refused while busy
    step(0, 1, 1, 5, 0);
    idle(7);
    step(0, 1, 1, 2, 0);
    step(0, 1, 1, 3, 0);
    idle(20);
    // D=3 on ch2 then disable
    step(0, 1, 2, 3, 0);
    idle(4);
    step(0, 1, 2, 0, 0);
    idle(12);
    // Unimplemented channel index
    step(0, 1, 3, 4, 0);
    // Reset while ch0 holds a staged update
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 6, 0);
    idle(2);
    step(0, 1, 0, 2, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(15);
    // Largest legal half-period
    step(0, 1, 2, 255, 0);
    idle(520);
`ifdef DIV_CTRL_SYNC_EN
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0);
    idle(2);
    step(0, 1, 1, 4, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    idle(10);
    step(0, 1, 1, 2, 1);
    idle(10);
`endif
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom % 100) == 0;
      v  = ($urandom % 4) == 0;
      ch = $urandom_range(0, 3);
      d  = (($urandom % 8) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 7);
      sy = 0;
`ifdef DIV_CTRL_SYNC_EN
      sy = ($urandom % 40) == 0;
`endif
      step(r, v, ch, d, sy);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 3, number of divider channels (1..4).
REQ-002 SHALL have parameter DIV_W, default 8, width of the per-channel half-period value.
REQ-003 SHALL have port CLK_in  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration write request.
REQ-006 SHALL have port cfg_ready  output  1  addressed channel can accept a write.
REQ-007 SHALL have port cfg_ch  input  2  target channel index.
REQ-008 SHALL have port cfg_div  input  DIV_W  half-period D in CLK_in cycles; 0 = disable.
REQ-009 SHALL have port clk_out  output  NCH  divided square waves.
REQ-010 SHALL have port tick  output  NCH  one-cycle pulse, high in the cycle after clk_out[i] changed.
REQ-011 SHALL have port busy  output  NCH  channel holds a pending, unapplied update.

Function
REQ-012 Per channel, the state machine SHALL have the states OFF, RUN and PEND.
REQ-013 Transfer SHALL occur when cfg_valid && cfg_ready; cfg_ready = !busy[cfg_ch], and is independent of cfg_valid; cfg_ch >= NCH SHALL read cfg_ready=1 and the write SHALL be dropped.
REQ-014 OFF + transfer with D!=0 SHALL go to RUN next cycle with cnt=0 and clk_out=0; D=0 SHALL leave the channel in OFF.
REQ-015 In RUN, cnt SHALL count 0..D-1; at cnt==D-1 the channel SHALL toggle clk_out, pulse tick and clear cnt, giving a period of 2*D cycles (D=1: CLK_in/2).
REQ-016 RUN + transfer SHALL stage D into a shadow register, go to PEND, and assert busy next cycle.
REQ-017 In PEND, the staged D SHALL be applied only at a terminal count where clk_out falls 1->0, so that no partial period occurs; cnt SHALL restart at 0 and the state SHALL become RUN; a staged 0 SHALL go to OFF with clk_out=0.
REQ-018 A transfer in the same cycle as a RUN terminal count SHALL go to PEND; the staged value SHALL NOT be applied before the next falling terminal count.
REQ-019 In OFF, clk_out, tick, busy and cnt SHALL all be 0.
REQ-020 cnt SHALL be DIV_W bits wide with no wrap: D = 2^DIV_W-1 is the largest legal value.
REQ-021 Channels SHALL be fully independent, and only one channel SHALL be written per cycle.

Reset
REQ-022 RST high at a CLK_in edge SHALL force all channels to OFF, clear cnt and the shadow registers, set clk_out=0, tick=0 and busy=0, and discard pending updates, including when RST is asserted mid-period.
REQ-023 cfg_ready SHALL be 1 in the cycle after RST deasserts.

Configuration
REQ-024 With DIV_CTRL_SYNC_EN defined, the block SHALL have port sync_in  input  1; sync_in high SHALL, on the next cycle, set cnt=0 and clk_out=0 on every RUN and PEND channel and apply any pending value immediately.
REQ-025 sync_in SHALL take priority over a terminal count; a transfer in the same cycle as sync_in SHALL be applied immediately.
REQ-026 Without DIV_CTRL_SYNC_EN, the sync_in port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-027 Package div_ctrl_pkg SHALL hold the NCH and DIV_W defaults, the channel state enum (OFF/RUN/PEND) and the channel-index type.
REQ-028 Sub-module div_ctrl_chan SHALL implement one channel (counter, shadow register, FSM) and SHALL be instantiated NCH times via generate; div_ctrl SHALL hold only the handshake decode and the output concatenation.

Verification
REQ-029 Reset, then write ch0 D=1 -> clk_out[0] toggles every cycle and tick[0] stays constantly high; ch1 and ch2 stay 0.
REQ-030 Write ch1 D=5 -> clk_out[1] has a period of 10 cycles with 5 high and 5 low, and a tick every 5 cycles.
REQ-031 ch1 running D=5, write D=2 mid-high-phase -> busy[1]=1 and cfg_ready=0 for ch1; the current period completes at 10 cycles, then periods are 4 cycles and busy clears.
REQ-032 Write ch2 D=0 while running D=3 -> the channel goes OFF at the next falling edge, clk_out[2] stays 0 and no further ticks occur.
REQ-033 RST pulse during PEND on ch0 -> all outputs are 0 next cycle, busy=0, and the staged value is never applied.
REQ-034 With DIV_CTRL_SYNC_EN, ch0 D=3 and ch1 D=4 at arbitrary phase, pulse sync_in -> both channels restart with cnt=0 and clk_out=0 together, and their first rising edges occur 3 and 4 cycles later respectively.
